// File: rtl/sdram_model.sv
// Behavioural single-rank SDRAM model with protocol checking, CAS-latency read pipeline and sticky error reporting.
// Define SDRAM_MODEL_TIMING_CHECK_EN to add per-bank tRCD/tRP/tRC checking (error codes 7-9).
module sdram_model #(
    parameter int BANKBITS = 1,
    parameter int ROWBITS  = 11,
    parameter int COLBITS  = 8,
    parameter int DWIDTH   = 16,
    parameter int MEMBITS  = 10,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3,
    parameter int T_RC     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pin_ras_n,
    input  logic                         pin_cas_n,
    input  logic                         pin_we_n,
    input  logic [BANKBITS+ROWBITS-1:0]  pin_addr,
    input  logic [DWIDTH-1:0]            pin_data_i,
    output logic [DWIDTH-1:0]            pin_data_o,
    output logic                         pin_data_oe,
    output logic                         err,
    output logic [3:0]                   err_code
);

    localparam int NBANK = 2**BANKBITS;

    typedef enum logic [2:0] {
        CMD_SET_MODE  = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_STOP      = 3'b110,
        CMD_NOP       = 3'b111
    } cmd_t;

    cmd_t                cmd;
    logic [BANKBITS-1:0] bank;
    logic [ROWBITS-1:0]  low;
    logic                a10;

    assign cmd  = cmd_t'({pin_ras_n, pin_cas_n, pin_we_n});
    assign bank = pin_addr[BANKBITS+ROWBITS-1:ROWBITS];
    assign low  = pin_addr[ROWBITS-1:0];
    assign a10  = low[10];

    logic [NBANK-1:0]   bank_open;
    logic [ROWBITS-1:0] bank_row [NBANK];
    logic               mode_valid;
    logic [1:0]         cl;
    logic [1:0]         pipe_v;
    logic [DWIDTH-1:0]  pipe_d [2];
    logic [DWIDTH-1:0]  mem [2**MEMBITS];
    logic [MEMBITS-1:0] mem_addr;
    logic [DWIDTH-1:0]  rd_data;
    logic [3:0]         code;
    logic               act_ok;
    logic               acc_ok;
    logic               rcd_early;
    logic               rp_early;
    logic               rc_early;
    logic               refresh_early;

    // Storage index is {open row, bank, col}; the high bits simply alias away.
    assign mem_addr = MEMBITS'({bank_row[bank], bank, low[COLBITS-1:0]});
    assign rd_data  = mem[mem_addr];
    assign act_ok   = (cmd == CMD_ACTIVE) && mode_valid && !bank_open[bank];
    assign acc_ok   = ((cmd == CMD_READ) || (cmd == CMD_WRITE)) && mode_valid && bank_open[bank];

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    localparam int             CW      = 8;
    localparam logic [CW-1:0]  CNT_MAX = '1;

    logic [CW-1:0] cnt_act [NBANK];
    logic [CW-1:0] cnt_pre [NBANK];

    always_comb begin
        rcd_early     = cnt_act[bank] < CW'(T_RCD);
        rp_early      = cnt_pre[bank] < CW'(T_RP);
        rc_early      = cnt_act[bank] < CW'(T_RC);
        refresh_early = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            if (cnt_pre[b] < CW'(T_RP)) refresh_early = 1'b1;
        end
    end

    // A counter value of k at an edge means the event happened k edges earlier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NBANK; b++) begin
                cnt_act[b] <= CNT_MAX;
                cnt_pre[b] <= CNT_MAX;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (cnt_act[b] != CNT_MAX) cnt_act[b] <= cnt_act[b] + CW'(1);
                if (cnt_pre[b] != CNT_MAX) cnt_pre[b] <= cnt_pre[b] + CW'(1);
            end
            if (act_ok) cnt_act[bank] <= CW'(1);
            if (cmd == CMD_PRECHARGE) begin
                if (a10) begin
                    for (int b = 0; b < NBANK; b++) cnt_pre[b] <= CW'(1);
                end else begin
                    cnt_pre[bank] <= CW'(1);
                end
            end
            if (acc_ok && a10) cnt_pre[bank] <= CW'(1);
        end
    end
`else
    assign rcd_early     = 1'b0;
    assign rp_early      = 1'b0;
    assign rc_early      = 1'b0;
    assign refresh_early = 1'b0;
`endif

    // Checks are ordered so the lowest applicable code wins.
    always_comb begin
        code = 4'd0;
        case (cmd)
            CMD_SET_MODE: begin
                if (low[5:4] != 2'd2 && low[5:4] != 2'd3) code = 4'd1;
            end
            CMD_REFRESH: begin
                if (|bank_open)         code = 4'd4;
                else if (refresh_early) code = 4'd8;
            end
            CMD_ACTIVE: begin
                if (!mode_valid)          code = 4'd2;
                else if (bank_open[bank]) code = 4'd3;
                else if (rp_early)        code = 4'd8;
                else if (rc_early)        code = 4'd9;
            end
            CMD_READ, CMD_WRITE: begin
                if (!mode_valid)                            code = 4'd2;
                else if (!bank_open[bank])                  code = 4'd5;
                else if (cmd == CMD_WRITE && pin_data_oe)   code = 4'd6;
                else if (rcd_early)                         code = 4'd7;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc_ok && cmd == CMD_WRITE) mem[mem_addr] <= pin_data_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_open   <= '0;
            for (int b = 0; b < NBANK; b++) bank_row[b] <= '0;
            mode_valid  <= 1'b0;
            cl          <= 2'd2;
            pipe_v      <= '0;
            pipe_d[0]   <= '0;
            pipe_d[1]   <= '0;
            pin_data_oe <= 1'b0;
            pin_data_o  <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            pin_data_oe <= pipe_v[0];
            pin_data_o  <= pipe_v[0] ? pipe_d[0] : '0;
            pipe_v      <= {1'b0, pipe_v[1]};
            pipe_d[0]   <= pipe_d[1];
            pipe_d[1]   <= '0;
            // CL3 enters one stage further back so it reaches the pins a cycle later.
            if (acc_ok && cmd == CMD_READ) begin
                if (cl == 2'd3) begin
                    pipe_v[1] <= 1'b1;
                    pipe_d[1] <= rd_data;
                end else begin
                    pipe_v[0] <= 1'b1;
                    pipe_d[0] <= rd_data;
                end
            end
            if (cmd == CMD_SET_MODE && code == 4'd0) begin
                cl         <= low[5:4];
                mode_valid <= 1'b1;
            end
            if (cmd == CMD_PRECHARGE) begin
                if (a10) bank_open <= '0;
                else     bank_open[bank] <= 1'b0;
            end
            if (act_ok) begin
                bank_open[bank] <= 1'b1;
                bank_row[bank]  <= low;
            end
            if (acc_ok && a10) bank_open[bank] <= 1'b0;
            if (!err && code != 4'd0) begin
                err      <= 1'b1;
                err_code <= code;
            end
        end
    end

endmodule

// File: tb/tb_sdram_model.sv
// Self-checking bench for sdram_model: directed protocol scenarios plus randomized traffic against a memory model.
module tb_sdram_model;

    localparam logic [2:0] C_MODE = 3'b000;
    localparam logic [2:0] C_REF  = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_WR   = 3'b100;
    localparam logic [2:0] C_RD   = 3'b101;
    localparam logic [2:0] C_NOP  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pin_ras_n, pin_cas_n, pin_we_n;
    logic [11:0] pin_addr;
    logic [15:0] pin_data_i;
    logic [15:0] pin_data_o;
    logic        pin_data_oe;
    logic        err;
    logic [3:0]  err_code;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [int];

    always #5 clk = ~clk;

    sdram_model dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pin_ras_n   (pin_ras_n),
        .pin_cas_n   (pin_cas_n),
        .pin_we_n    (pin_we_n),
        .pin_addr    (pin_addr),
        .pin_data_i  (pin_data_i),
        .pin_data_o  (pin_data_o),
        .pin_data_oe (pin_data_oe),
        .err         (err),
        .err_code    (err_code)
    );

    // Word index as the device sees it: row*512 + bank*256 + col, wrapped to 1024 words.
    function automatic int maddr(input int row, input int b, input int col);
        return (row * 512 + b * 256 + col) % 1024;
    endfunction

    task automatic set_nop();
        {pin_ras_n, pin_cas_n, pin_we_n} = C_NOP;
        pin_addr   = '0;
        pin_data_i = '0;
    endtask

    task automatic issue(input logic [2:0] c, input logic b, input logic [10:0] low, input logic [15:0] d);
        {pin_ras_n, pin_cas_n, pin_we_n} = c;
        pin_addr   = {b, low};
        pin_data_i = d;
        @(posedge clk);
        #1;
        set_nop();
    endtask

    task automatic nops(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        set_nop();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        reset_n = 1'b0;
        #3;
        checks++;
        if (pin_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", pin_data_oe); end
        checks++;
        if (pin_data_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", pin_data_o); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (err_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", err_code); end
        do_reset();
    endtask

    task automatic test_read_latency();
        do_reset();
        issue(C_MODE, 1'b0, 11'h030, 16'h0);
        nops(2);
        issue(C_ACT, 1'b0, 11'd5, 16'h0);
        nops(3);
        issue(C_WR, 1'b0, 11'h012, 16'hBEEF);
        issue(C_RD, 1'b0, 11'h012, 16'h0);
        checks++;
        if (pin_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL lat_s1_oe: got %b expected 0", pin_data_oe); end
        nops(1);
        checks++;
        if (pin_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL lat_s2_oe: got %b expected 0", pin_data_oe); end
        nops(1);
        checks++;
        if (pin_data_oe !== 1'b1 || pin_data_o !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL lat_s3_data: got oe=%b data=%h expected oe=1 data=beef", pin_data_oe, pin_data_o);
        end
        nops(1);
        checks++;
        if (pin_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL lat_s4_oe: got %b expected 0", pin_data_oe); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL lat_err: got %b expected 0", err); end
    endtask

    task automatic test_burst();
        logic [15:0] e;
        do_reset();
        issue(C_MODE, 1'b0, 11'h020, 16'h0);
        nops(2);
        issue(C_ACT, 1'b0, 11'd7, 16'h0);
        nops(3);
        for (int i = 0; i < 4; i++) issue(C_WR, 1'b0, 11'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 6; i++) begin
            if (i < 4) issue(C_RD, 1'b0, 11'(i), 16'h0);
            else       nops(1);
            checks++;
            if (i >= 1 && i <= 4) begin
                e = 16'(16'h1111 * i);
                if (pin_data_oe !== 1'b1 || pin_data_o !== e) begin
                    errors++; $display("[TB] FAIL burst_%0d: got oe=%b data=%h expected oe=1 data=%h", i, pin_data_oe, pin_data_o, e);
                end
            end else if (pin_data_oe !== 1'b0) begin
                errors++; $display("[TB] FAIL burst_idle_%0d: got oe=%b expected 0", i, pin_data_oe);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL burst_err: got %b expected 0", err); end
    endtask

    task automatic test_closed_bank();
        logic oe_seen;
        do_reset();
        issue(C_MODE, 1'b0, 11'h020, 16'h0);
        nops(2);
        issue(C_RD, 1'b0, 11'h012, 16'h0);
        oe_seen = 1'b0;
        repeat (4) begin
            if (pin_data_oe !== 1'b0) oe_seen = 1'b1;
            nops(1);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL closed_err: got %b expected 1", err); end
        checks++;
        if (err_code !== 4'd5) begin errors++; $display("[TB] FAIL closed_code: got %0d expected 5", err_code); end
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("[TB] FAIL closed_oe: got %b expected 0", oe_seen); end
    endtask

    task automatic test_trcd();
        do_reset();
        issue(C_MODE, 1'b0, 11'h020, 16'h0);
        nops(2);
        issue(C_ACT, 1'b0, 11'd9, 16'h0);
        nops(8);
        issue(C_WR, 1'b0, 11'h033, 16'h5A5A);
        issue(C_PRE, 1'b0, 11'h400, 16'h0);
        nops(8);
        issue(C_ACT, 1'b0, 11'd9, 16'h0);
        issue(C_RD, 1'b0, 11'h033, 16'h0);
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
        checks++;
        if (err !== 1'b1 || err_code !== 4'd7) begin
            errors++; $display("[TB] FAIL trcd_code: got err=%b code=%0d expected err=1 code=7", err, err_code);
        end
`else
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL trcd_err: got %b expected 0", err); end
        nops(1);
        checks++;
        if (pin_data_oe !== 1'b1 || pin_data_o !== 16'h5A5A) begin
            errors++; $display("[TB] FAIL trcd_data: got oe=%b data=%h expected oe=1 data=5a5a", pin_data_oe, pin_data_o);
        end
`endif
    endtask

    task automatic test_first_error();
        do_reset();
        issue(C_MODE, 1'b0, 11'h020, 16'h0);
        nops(2);
        issue(C_PRE, 1'b0, 11'h400, 16'h0);
        nops(4);
        issue(C_REF, 1'b0, 11'h000, 16'h0);
        issue(C_ACT, 1'b1, 11'd20, 16'h0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL first_clean: got err=%b code=%0d expected err=0", err, err_code); end
        issue(C_ACT, 1'b1, 11'd21, 16'h0);
        checks++;
        if (err !== 1'b1 || err_code !== 4'd3) begin
            errors++; $display("[TB] FAIL first_code: got err=%b code=%0d expected err=1 code=3", err, err_code);
        end
        issue(C_RD, 1'b0, 11'h001, 16'h0);
        nops(2);
        checks++;
        if (err !== 1'b1 || err_code !== 4'd3) begin
            errors++; $display("[TB] FAIL first_hold: got err=%b code=%0d expected err=1 code=3", err, err_code);
        end
    endtask

    task automatic test_reset_mid_read();
        logic oe_seen;
        do_reset();
        issue(C_MODE, 1'b0, 11'h030, 16'h0);
        nops(2);
        issue(C_ACT, 1'b0, 11'd3, 16'h0);
        nops(3);
        issue(C_WR, 1'b0, 11'h004, 16'h1234);
        issue(C_RD, 1'b0, 11'h004, 16'h0);
        nops(1);
        reset_n = 1'b0;
        oe_seen = 1'b0;
        repeat (3) begin
            if (pin_data_oe !== 1'b0) oe_seen = 1'b1;
            nops(1);
        end
        reset_n = 1'b1;
        repeat (5) begin
            if (pin_data_oe !== 1'b0) oe_seen = 1'b1;
            nops(1);
        end
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("[TB] FAIL midread_oe: got %b expected 0", oe_seen); end
        checks++;
        if (err !== 1'b0 || err_code !== 4'd0) begin
            errors++; $display("[TB] FAIL midread_err: got err=%b code=%0d expected err=0 code=0", err, err_code);
        end
        issue(C_MODE, 1'b0, 11'h030, 16'h0);
        nops(2);
        issue(C_ACT, 1'b0, 11'd3, 16'h0);
        nops(3);
        issue(C_RD, 1'b0, 11'h004, 16'h0);
        nops(2);
        checks++;
        if (pin_data_oe !== 1'b1 || pin_data_o !== 16'h1234) begin
            errors++; $display("[TB] FAIL midread_keep: got oe=%b data=%h expected oe=1 data=1234", pin_data_oe, pin_data_o);
        end
    endtask

    task automatic test_random();
        int          cl;
        int          rows [2];
        int          wb [24];
        int          wc [24];
        int          rb [16];
        int          rc [16];
        logic [15:0] ex [16];
        logic [15:0] d;
        int          k;
        int          j;
        int          alias_row;
        do_reset();
        cl = int'($urandom_range(2, 3));
        issue(C_MODE, 1'b0, 11'(cl * 16), 16'h0);
        nops(2);
        for (int b = 0; b < 2; b++) begin
            rows[b] = int'($urandom_range(0, 2047)) & 11'h3FF;
            issue(C_ACT, 1'(b), 11'(rows[b]), 16'h0);
            nops(8);
        end
        for (int i = 0; i < 24; i++) begin
            wb[i] = (i == 0) ? 0 : int'($urandom_range(0, 1));
            wc[i] = int'($urandom_range(0, 255));
            d     = 16'($urandom);
            ref_mem[maddr(rows[wb[i]], wb[i], wc[i])] = d;
            issue(C_WR, 1'(wb[i]), 11'(wc[i]), d);
        end
        for (int i = 0; i < 16; i++) begin
            k     = int'($urandom_range(0, 23));
            rb[i] = wb[k];
            rc[i] = wc[k];
            ex[i] = ref_mem[maddr(rows[rb[i]], rb[i], rc[i])];
        end
        for (int i = 0; i < 16 + cl; i++) begin
            if (i < 16) issue(C_RD, 1'(rb[i]), 11'(rc[i]), 16'h0);
            else        nops(1);
            j = i - (cl - 1);
            checks++;
            if (j >= 0 && j < 16) begin
                if (pin_data_oe !== 1'b1 || pin_data_o !== ex[j]) begin
                    errors++; $display("[TB] FAIL rand_rd_%0d: got oe=%b data=%h expected oe=1 data=%h (cl=%0d)", j, pin_data_oe, pin_data_o, ex[j], cl);
                end
            end else if (pin_data_oe !== 1'b0) begin
                errors++; $display("[TB] FAIL rand_idle_%0d: got oe=%b expected 0", i, pin_data_oe);
            end
        end
        // A row differing only above the storage index must alias onto the same words.
        issue(C_PRE, 1'b0, 11'h400, 16'h0);
        nops(8);
        alias_row = rows[0] ^ 11'h402;
        issue(C_ACT, 1'b0, 11'(alias_row), 16'h0);
        nops(4);
        issue(C_RD, 1'b0, 11'(wc[0]), 16'h0);
        nops(cl - 1);
        checks++;
        if (pin_data_oe !== 1'b1 || pin_data_o !== ref_mem[maddr(alias_row, 0, wc[0])]) begin
            errors++; $display("[TB] FAIL rand_alias: got oe=%b data=%h expected oe=1 data=%h", pin_data_oe, pin_data_o, ref_mem[maddr(alias_row, 0, wc[0])]);
        end
        nops(2);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL rand_err: got err=%b code=%0d expected err=0", err, err_code); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        set_nop();
        test_reset();
        test_read_latency();
        test_burst();
        test_closed_bank();
        test_trcd();
        test_first_error();
        test_reset_mid_read();
        for (int r = 0; r < 3; r++) test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
